// File: rtl/cdm_msgld_req_arbiter.sv
// cdm_msgld_req_arbiter: round-robin share of one CDM MSGLD request channel among NUM_REQ
// requesters, with per-requester outstanding tracking and cookie-based response routing.
// Optional statistics counters (grant_cnt, stall_cnt) are built when CDM_MSGLD_ARB_STATS_EN
// is defined.
module cdm_msgld_req_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_OUTS   = 8,
    parameter int unsigned DAT_W      = 256,
    parameter logic [3:0]  COOKIE_TAG = 4'hA,
    parameter int unsigned TCQ        = 1
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_vld,
    output logic [NUM_REQ-1:0]    req_rdy,
    input  logic [NUM_REQ*64-1:0] req_addr,
    input  logic [NUM_REQ*9-1:0]  req_len,
    output logic                  msgld_vld,
    input  logic                  msgld_rdy,
    output logic [63:0]           msgld_addr,
    output logic [8:0]            msgld_len,
    output logic [11:0]           msgld_cookie,
    input  logic                  rsp_vld,
    output logic                  rsp_rdy,
    input  logic [11:0]           rsp_cookie,
    input  logic [DAT_W-1:0]      rsp_data,
    output logic [NUM_REQ-1:0]    cl_rsp_vld,
    input  logic [NUM_REQ-1:0]    cl_rsp_rdy,
    output logic [DAT_W-1:0]      cl_rsp_data,
    output logic [NUM_REQ*8-1:0]  outs_cnt,
    output logic                  cookie_err
`ifdef CDM_MSGLD_ARB_STATS_EN
    ,
    output logic [31:0]           grant_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  MAX_OUTS_B = 8'(MAX_OUTS);

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]           cnt_q [NUM_REQ];
    logic [7:0]           cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0]   eligible;
    logic [2*NUM_REQ-1:0] elig_rot;
    logic                 stage_load;
    logic                 grant_vld;
    logic [3:0]           grant_idx;
    logic [63:0]          sel_addr;
    logic [8:0]           sel_len;
    logic [3:0]           rsp_idx;
    logic                 tag_ok;
    logic [NUM_REQ-1:0]   rsp_hit;
    logic                 rsp_ok;
    logic [31:0]          unused_tcq;
    logic                 unused_cookie_lsb;

    assign unused_tcq        = TCQ;
    assign unused_cookie_lsb = ^rsp_cookie[3:0];

    // Round-robin grant: rotate the eligible vector so the pointer sits at bit 0, take the
    // lowest set bit, and map the offset back to a requester index.
    always_comb begin
        int unsigned s;
        stage_load = !msgld_vld || msgld_rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_vld[i] && (cnt_q[i] < MAX_OUTS_B) && en;
        end
        elig_rot  = {eligible, eligible} >> rr_ptr_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_ptr_d  = rr_ptr_q;
        s         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stage_load && !grant_vld && elig_rot[i]) begin
                grant_vld = 1'b1;
                s         = 32'(rr_ptr_q) + 32'(i);
                if (s >= NUM_REQ) s = s - NUM_REQ;
                grant_idx = 4'(s);
                rr_ptr_d  = (s + 1 >= NUM_REQ) ? '0 : PTR_W'(s + 1);
            end
        end
        req_rdy  = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && grant_idx == 4'(i)) begin
                req_rdy[i] = 1'b1;
                sel_addr   = req_addr[i*64 +: 64];
                sel_len    = req_len[i*9 +: 9];
            end
        end
    end

    // Response decode and pass-through; undecodable beats are acked and dropped.
    always_comb begin
        rsp_idx = rsp_cookie[7:4];
        tag_ok  = (rsp_cookie[11:8] == COOKIE_TAG);
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_hit[i] = (rsp_idx == 4'(i)) && (cnt_q[i] != 8'd0);
        end
        rsp_ok      = tag_ok && (|rsp_hit);
        cl_rsp_vld  = (rsp_vld && rsp_ok) ? rsp_hit : '0;
        rsp_rdy     = rsp_ok ? |(rsp_hit & cl_rsp_rdy) : 1'b1;
        cl_rsp_data = rsp_data;
    end

    // Outstanding counters: +1 on grant, -1 on routed response handshake.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            unique case ({req_rdy[i], cl_rsp_vld[i] && cl_rsp_rdy[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 8'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 8'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
            outs_cnt[i*8 +: 8] = cnt_q[i];
        end
    end

    // State registers: pointer, counters, output stage and sticky error.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rr_ptr_q     <= '0;
            msgld_vld    <= 1'b0;
            msgld_addr   <= '0;
            msgld_len    <= '0;
            msgld_cookie <= '0;
            cookie_err   <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
            if (grant_vld) begin
                msgld_vld    <= 1'b1;
                msgld_addr   <= sel_addr;
                msgld_len    <= sel_len;
                msgld_cookie <= {COOKIE_TAG, grant_idx, 4'h1};
            end else if (msgld_rdy) begin
                msgld_vld <= 1'b0;
            end
            if (rsp_vld && !rsp_ok) cookie_err <= 1'b1;
        end
    end

`ifdef CDM_MSGLD_ARB_STATS_EN
    logic stall_now;

    // A stall cycle: some requester wants to issue but only its outstanding limit stops it.
    always_comb begin
        stall_now = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_vld[i] && en && cnt_q[i] == MAX_OUTS_B) stall_now = 1'b1;
        end
    end

    // Handshake counter wraps; stall counter saturates.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (msgld_vld && msgld_rdy) grant_cnt <= grant_cnt + 32'd1;
            if (stall_now && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdm_msgld_req_arbiter.sv
// Directed self-checking bench for cdm_msgld_req_arbiter (NUM_REQ=4, MAX_OUTS=8).
module tb_cdm_msgld_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 256;

    logic              user_clk = 1'b0;
    logic              user_reset;
    logic              en;
    logic [NR-1:0]     req_vld;
    logic [NR-1:0]     req_rdy;
    logic [NR*64-1:0]  req_addr;
    logic [NR*9-1:0]   req_len;
    logic              msgld_vld;
    logic              msgld_rdy;
    logic [63:0]       msgld_addr;
    logic [8:0]        msgld_len;
    logic [11:0]       msgld_cookie;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [11:0]       rsp_cookie;
    logic [DW-1:0]     rsp_data;
    logic [NR-1:0]     cl_rsp_vld;
    logic [NR-1:0]     cl_rsp_rdy;
    logic [DW-1:0]     cl_rsp_data;
    logic [NR*8-1:0]   outs_cnt;
    logic              cookie_err;
`ifdef CDM_MSGLD_ARB_STATS_EN
    logic [31:0]       grant_cnt;
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 user_clk = ~user_clk;

    cdm_msgld_req_arbiter dut (
        .user_clk     (user_clk),
        .user_reset   (user_reset),
        .en           (en),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .msgld_vld    (msgld_vld),
        .msgld_rdy    (msgld_rdy),
        .msgld_addr   (msgld_addr),
        .msgld_len    (msgld_len),
        .msgld_cookie (msgld_cookie),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .rsp_cookie   (rsp_cookie),
        .rsp_data     (rsp_data),
        .cl_rsp_vld   (cl_rsp_vld),
        .cl_rsp_rdy   (cl_rsp_rdy),
        .cl_rsp_data  (cl_rsp_data),
        .outs_cnt     (outs_cnt),
        .cookie_err   (cookie_err)
`ifdef CDM_MSGLD_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    function automatic logic [63:0] addr_of(int i);
        return 64'hCAFE_0000_0000_0000 | 64'(i * 16);
    endfunction

    function automatic logic [8:0] len_of(int i);
        return 9'(32 + i);
    endfunction

    function automatic logic [11:0] ck(int i);
        return {4'hA, 4'(i), 4'h1};
    endfunction

    function automatic logic [7:0] cnt_of(int i);
        return outs_cnt[i*8 +: 8];
    endfunction

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        en         = 1'b1;
        req_vld    = '0;
        msgld_rdy  = 1'b1;
        rsp_vld    = 1'b0;
        rsp_cookie = '0;
        cl_rsp_rdy = '1;
        step();
        step();
        user_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (msgld_vld !== 1'b0 || msgld_addr !== 64'd0 || msgld_len !== 9'd0) begin
            errors++;
            $display("FAIL reset_stage: vld=%b addr=%h len=%h, want 0/0/0",
                     msgld_vld, msgld_addr, msgld_len);
        end
        checks++;
        if (msgld_cookie !== 12'h000 || outs_cnt !== '0 || cookie_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cookie=%h outs=%h err=%b, want 000/0/0",
                     msgld_cookie, outs_cnt, cookie_err);
        end
`ifdef CDM_MSGLD_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: grant=%0d stall=%0d, want 0/0", grant_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        do_reset();
        req_vld = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first: req_rdy=%b want 0001", req_rdy);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            #1;
            exp_rdy = 4'(1 << (k % 4));
            checks++;
            if (msgld_vld !== 1'b1 || msgld_cookie !== ck((k - 1) % 4) ||
                msgld_addr !== addr_of((k - 1) % 4) || msgld_len !== len_of((k - 1) % 4)) begin
                errors++;
                $display("FAIL rr_stage[%0d]: vld=%b cookie=%h addr=%h len=%h, want 1 %h %h %h",
                         k, msgld_vld, msgld_cookie, msgld_addr, msgld_len,
                         ck((k - 1) % 4), addr_of((k - 1) % 4), len_of((k - 1) % 4));
            end
            checks++;
            if (req_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: req_rdy=%b want %b", k, req_rdy, exp_rdy);
            end
        end
        checks++;
        if (outs_cnt !== {8'd2, 8'd2, 8'd2, 8'd2}) begin
            errors++;
            $display("FAIL rr_outs: outs_cnt=%h want 02020202", outs_cnt);
        end
        req_vld = '0;
        step();
    endtask

    task automatic test_outs_limit();
        do_reset();
        req_vld = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_rdy !== 4'b0100) begin
                errors++;
                $display("FAIL lim_grant[%0d]: req_rdy=%b want 0100", k, req_rdy);
            end
            step();
        end
        #1;
        checks++;
        if (cnt_of(2) !== 8'd8 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL lim_full: outs2=%0d req_rdy=%b want 8/0000", cnt_of(2), req_rdy);
        end
        rsp_vld    = 1'b1;
        rsp_cookie = 12'hA21;
        #1;
        checks++;
        if (cl_rsp_vld !== 4'b0100 || rsp_rdy !== 1'b1 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL lim_rsp: cl_vld=%b rsp_rdy=%b req_rdy=%b want 0100/1/0000",
                     cl_rsp_vld, rsp_rdy, req_rdy);
        end
        step();
        rsp_vld = 1'b0;
        #1;
        checks++;
        if (cnt_of(2) !== 8'd7 || req_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL lim_reopen: outs2=%0d req_rdy=%b want 7/0100", cnt_of(2), req_rdy);
        end
        step();
        #1;
        checks++;
        if (cnt_of(2) !== 8'd8 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL lim_refull: outs2=%0d req_rdy=%b want 8/0000", cnt_of(2), req_rdy);
        end
        req_vld = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        msgld_rdy = 1'b0;
        req_vld   = 4'b0011;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first: req_rdy=%b want 0001", req_rdy);
        end
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (msgld_vld !== 1'b1 || msgld_addr !== addr_of(0) || msgld_len !== len_of(0) ||
                msgld_cookie !== 12'hA01 || req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b addr=%h len=%h cookie=%h req_rdy=%b",
                         c, msgld_vld, msgld_addr, msgld_len, msgld_cookie, req_rdy);
            end
            step();
        end
        msgld_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release: req_rdy=%b want 0010", req_rdy);
        end
        step();
        #1;
        checks++;
        if (msgld_cookie !== 12'hA11 || msgld_addr !== addr_of(1)) begin
            errors++;
            $display("FAIL bp_next: cookie=%h addr=%h want a11 %h",
                     msgld_cookie, msgld_addr, addr_of(1));
        end
        en      = 1'b0;
        req_vld = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL en_off: req_rdy=%b want 0000", req_rdy);
        end
        req_vld = '0;
        en      = 1'b1;
    endtask

    task automatic test_rsp_routing();
        do_reset();
        req_vld = 4'b0010;
        step();
        req_vld = '0;
        step();
        rsp_vld    = 1'b1;
        rsp_cookie = 12'hA11;
        rsp_data   = {8{32'hDEAD_BEEF}};
        cl_rsp_rdy = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (cl_rsp_vld !== 4'b0010 || rsp_rdy !== 1'b0 || cl_rsp_data !== {8{32'hDEAD_BEEF}}) begin
                errors++;
                $display("FAIL route_stall[%0d]: cl_vld=%b rsp_rdy=%b want 0010/0",
                         c, cl_rsp_vld, rsp_rdy);
            end
            step();
        end
        cl_rsp_rdy = 4'hF;
        #1;
        checks++;
        if (rsp_rdy !== 1'b1 || cnt_of(1) !== 8'd1) begin
            errors++;
            $display("FAIL route_go: rsp_rdy=%b outs1=%0d want 1/1", rsp_rdy, cnt_of(1));
        end
        step();
        rsp_vld = 1'b0;
        #1;
        checks++;
        if (cnt_of(1) !== 8'd0 || cookie_err !== 1'b0) begin
            errors++;
            $display("FAIL route_done: outs1=%0d err=%b want 0/0", cnt_of(1), cookie_err);
        end
    endtask

    task automatic test_bad_cookie();
        do_reset();
        rsp_vld    = 1'b1;
        rsp_cookie = 12'hB01;
        #1;
        checks++;
        if (rsp_rdy !== 1'b1 || cl_rsp_vld !== 4'b0000 || cookie_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_tag: rsp_rdy=%b cl_vld=%b err=%b want 1/0000/0",
                     rsp_rdy, cl_rsp_vld, cookie_err);
        end
        step();
        #1;
        checks++;
        if (cookie_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_err_set: err=%b want 1", cookie_err);
        end
        rsp_cookie = 12'hA51;
        #1;
        checks++;
        if (rsp_rdy !== 1'b1 || cl_rsp_vld !== 4'b0000) begin
            errors++;
            $display("FAIL bad_idx: rsp_rdy=%b cl_vld=%b want 1/0000", rsp_rdy, cl_rsp_vld);
        end
        step();
        rsp_cookie = 12'hA01;
        #1;
        checks++;
        if (rsp_rdy !== 1'b1 || cl_rsp_vld !== 4'b0000) begin
            errors++;
            $display("FAIL bad_underflow: rsp_rdy=%b cl_vld=%b want 1/0000", rsp_rdy, cl_rsp_vld);
        end
        step();
        rsp_vld = 1'b0;
        step();
        #1;
        checks++;
        if (cookie_err !== 1'b1 || outs_cnt !== '0) begin
            errors++;
            $display("FAIL bad_sticky: err=%b outs=%h want 1/00000000", cookie_err, outs_cnt);
        end
    endtask

    task automatic test_simul_and_reset();
        do_reset();
        req_vld = 4'b0001;
        step();
        req_vld = '0;
        step();
        req_vld    = 4'b0001;
        rsp_vld    = 1'b1;
        rsp_cookie = 12'hA01;
        #1;
        checks++;
        if (req_rdy !== 4'b0001 || cl_rsp_vld !== 4'b0001 || rsp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL simul_pre: req_rdy=%b cl_vld=%b rsp_rdy=%b want 0001/0001/1",
                     req_rdy, cl_rsp_vld, rsp_rdy);
        end
        step();
        rsp_vld = 1'b0;
        req_vld = '0;
        #1;
        checks++;
        if (cnt_of(0) !== 8'd1) begin
            errors++;
            $display("FAIL simul_cnt: outs0=%0d want 1", cnt_of(0));
        end
        req_vld    = 4'b0001;
        rsp_vld    = 1'b1;
        rsp_cookie = 12'hB01;
        step();
        rsp_vld = 1'b0;
        step();
        #1;
        checks++;
        if (cnt_of(0) !== 8'd3 || cookie_err !== 1'b1 || msgld_vld !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: outs0=%0d err=%b vld=%b want 3/1/1",
                     cnt_of(0), cookie_err, msgld_vld);
        end
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        req_vld    = '0;
        #1;
        checks++;
        if (msgld_vld !== 1'b0 || msgld_addr !== 64'd0 || msgld_len !== 9'd0 ||
            msgld_cookie !== 12'h000 || outs_cnt !== '0 || cookie_err !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: vld=%b addr=%h len=%h cookie=%h outs=%h err=%b",
                     msgld_vld, msgld_addr, msgld_len, msgld_cookie, outs_cnt, cookie_err);
        end
`ifdef CDM_MSGLD_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midop_stats: grant_cnt=%0d want 0", grant_cnt);
        end
`endif
        req_vld = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL midop_ptr: req_rdy=%b want 0001", req_rdy);
        end
        req_vld = '0;
        step();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*64 +: 64] = addr_of(i);
            req_len[i*9 +: 9]    = len_of(i);
        end
        rsp_data = '0;
        test_reset();
        test_round_robin();
        test_outs_limit();
        test_backpressure();
        test_rsp_routing();
        test_bad_cookie();
        test_simul_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
